qpp_interleaver: RTL and testbench

Parametrised ping-pong block interleaver for the turbo encoder path. It generalises the fixed small/large two-table design to any runtime block size K up to K_MAX. Addresses are generated on the fly with the QPP permutation pi(i) = (f1*i + f2*i^2) mod K, so no per-size address ROMs are needed. Two banks let block n+1 be written while block n is read out permuted, with valid/ready handshakes on both sides.

---
 rtl/qpp_interleaver.sv | 231 +++++++++++++++++++++++
 tb/tb_qpp_interleaver.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qpp_interleaver.sv
// Ping-pong block interleaver with on-the-fly QPP address generation.
// One bank fills in natural order while the other drains in pi(i) order.
module qpp_interleaver #(
  parameter int DATA_W = 1,
  parameter int K_MAX  = 6144,
  parameter int AW     = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CRC_start,
  input  logic [AW-1:0]     blk_k,
  input  logic [AW-1:0]     f1,
  input  logic [AW-1:0]     f2,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              cfg_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              done
);

  typedef enum logic {W_IDLE, W_FILL} wr_state_e;
  typedef enum logic {R_IDLE, R_DRAIN} rd_state_e;

  function automatic logic [AW-1:0] mod_add(
    input logic [AW-1:0] a,
    input logic [AW-1:0] b,
    input logic [AW-1:0] k
  );
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, k}) s = s - {1'b0, k};
    return s[AW-1:0];
  endfunction

  logic [DATA_W-1:0] mem0 [K_MAX];
  logic [DATA_W-1:0] mem1 [K_MAX];

  wr_state_e   wr_state_q, wr_state_d;
  logic        wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [1:0]  full_q, full_d;
  logic [AW-1:0] k_q [2], k_d [2];
  logic [AW-1:0] f1_q [2], f1_d [2];
  logic [AW-1:0] f2_q [2], f2_d [2];
  logic        cfg_err_q, cfg_err_d;

  rd_state_e   rd_state_q, rd_state_d;
  logic        rd_bank_q, rd_bank_d;
  logic [AW-1:0] pi_q, pi_d, g_q, g_d, d2_q, d2_d;
  logic [AW-1:0] kr_q, kr_d, cnt_q, cnt_d;
  logic        ov_q, ov_d, ol_q, ol_d;
  logic [DATA_W-1:0] od_q, od_d;

  logic          cfg_ok, tgt_free, wr_en, adv, blk_end;
  logic          rd_en, rd_sel, ld_b;
  logic [AW-1:0] rd_addr, ld_k, ld_g0, ld_d2;

  assign in_ready  = (wr_state_q == W_FILL);
  assign cfg_err   = cfg_err_q;
  assign out_valid = ov_q;
  assign out_last  = ol_q;
  assign out_data  = od_q;
  assign done      = blk_end;

  assign adv     = !ov_q || out_ready;
  assign blk_end = ov_q && out_ready && ol_q;
  assign wr_en   = in_ready && in_valid;

  assign cfg_ok = (blk_k >= AW'(40)) && (blk_k <= AW'(K_MAX)) &&
                  (blk_k[2:0] == 3'd0) && (f1 < blk_k) && (f2 < blk_k);
  // A bank being released this very cycle already counts as free.
  assign tgt_free = !full_q[wr_bank_q] ||
                    (blk_end && (rd_bank_q == wr_bank_q));

  assign ld_b  = (rd_state_q == R_IDLE) ? rd_bank_q : !rd_bank_q;
  assign ld_k  = k_q[ld_b];
  assign ld_g0 = mod_add(f1_q[ld_b], f2_q[ld_b], ld_k);
  assign ld_d2 = mod_add(f2_q[ld_b], f2_q[ld_b], ld_k);

  always_comb begin
    wr_state_d = wr_state_q;
    wr_bank_d  = wr_bank_q;
    wr_idx_d   = wr_idx_q;
    full_d     = full_q;
    k_d        = k_q;
    f1_d       = f1_q;
    f2_d       = f2_q;
    cfg_err_d  = 1'b0;
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    pi_d       = pi_q;
    g_d        = g_q;
    d2_d       = d2_q;
    kr_d       = kr_q;
    cnt_d      = cnt_q;
    ov_d       = ov_q;
    ol_d       = ol_q;
    rd_en      = 1'b0;
    rd_sel     = rd_bank_q;
    rd_addr    = pi_q;

    unique case (wr_state_q)
      W_IDLE: begin
        if (CRC_start) begin
          if (cfg_ok && tgt_free) begin
            wr_state_d     = W_FILL;
            wr_idx_d       = '0;
            k_d[wr_bank_q]  = blk_k;
            f1_d[wr_bank_q] = f1;
            f2_d[wr_bank_q] = f2;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      W_FILL: begin
        if (CRC_start) cfg_err_d = 1'b1;
        if (in_valid) begin
          wr_idx_d = wr_idx_q + AW'(1);
          if (wr_idx_q == k_q[wr_bank_q] - AW'(1)) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            wr_state_d        = W_IDLE;
          end
        end
      end
      default: wr_state_d = W_IDLE;
    endcase

    unique case (rd_state_q)
      R_IDLE: begin
        if (full_q[rd_bank_q]) begin
          rd_state_d = R_DRAIN;
          pi_d       = '0;
          g_d        = ld_g0;
          d2_d       = ld_d2;
          kr_d       = ld_k;
          cnt_d      = '0;
        end
      end
      R_DRAIN: begin
        if (blk_end) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = !rd_bank_q;
          // Issue address 0 of the next bank now so output stays gapless.
          if (full_q[!rd_bank_q]) begin
            rd_en   = 1'b1;
            rd_sel  = !rd_bank_q;
            rd_addr = '0;
            pi_d    = ld_g0;
            g_d     = mod_add(ld_g0, ld_d2, ld_k);
            d2_d    = ld_d2;
            kr_d    = ld_k;
            cnt_d   = AW'(1);
            ov_d    = 1'b1;
            ol_d    = 1'b0;
          end else begin
            rd_state_d = R_IDLE;
            ov_d       = 1'b0;
            ol_d       = 1'b0;
          end
        end else if (adv && (cnt_q != kr_q)) begin
          rd_en = 1'b1;
          pi_d  = mod_add(pi_q, g_q, kr_q);
          g_d   = mod_add(g_q, d2_q, kr_q);
          cnt_d = cnt_q + AW'(1);
          ov_d  = 1'b1;
          ol_d  = (cnt_q == kr_q - AW'(1));
        end
      end
      default: rd_state_d = R_IDLE;
    endcase

    od_d = od_q;
    if (rd_en) od_d = rd_sel ? mem1[rd_addr] : mem0[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank_q) mem1[wr_idx_q] <= in_data;
      else           mem0[wr_idx_q] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_q <= W_IDLE;
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      full_q     <= '0;
      k_q        <= '{default: '0};
      f1_q       <= '{default: '0};
      f2_q       <= '{default: '0};
      cfg_err_q  <= 1'b0;
      rd_state_q <= R_IDLE;
      rd_bank_q  <= 1'b0;
      pi_q       <= '0;
      g_q        <= '0;
      d2_q       <= '0;
      kr_q       <= '0;
      cnt_q      <= '0;
      ov_q       <= 1'b0;
      ol_q       <= 1'b0;
      od_q       <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_bank_q  <= wr_bank_d;
      wr_idx_q   <= wr_idx_d;
      full_q     <= full_d;
      k_q        <= k_d;
      f1_q       <= f1_d;
      f2_q       <= f2_d;
      cfg_err_q  <= cfg_err_d;
      rd_state_q <= rd_state_d;
      rd_bank_q  <= rd_bank_d;
      pi_q       <= pi_d;
      g_q        <= g_d;
      d2_q       <= d2_d;
      kr_q       <= kr_d;
      cnt_q      <= cnt_d;
      ov_q       <= ov_d;
      ol_q       <= ol_d;
      od_q       <= od_d;
    end
  end

endmodule

// File: tb/tb_qpp_interleaver.sv
// Directed bench for qpp_interleaver: checks the QPP order against
// (f1*i + f2*i^2) mod K and the handshake, ping-pong, error and reset paths.
module tb_qpp_interleaver;

  localparam int DW = 8;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          CRC_start;
  logic [AW-1:0] blk_k, f1, f2;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready, cfg_err, out_valid, out_last, out_ready, done;
  logic [DW-1:0] out_data;

  qpp_interleaver #(.DATA_W(DW), .K_MAX(6144), .AW(AW)) dut (
    .clk(clk), .reset(reset), .CRC_start(CRC_start),
    .blk_k(blk_k), .f1(f1), .f2(f2),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cfg_err(cfg_err), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit overlap;
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] exp_q[$];
  bit last_q[$];
  logic [DW-1:0] tmp [6144];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic gen_block(input int k, input int a, input int b,
                           input bit rnd);
    longint p;
    for (int i = 0; i < k; i++) begin
      tmp[i] = rnd ? DW'($urandom) : DW'(i);
      in_q.push_back(tmp[i]);
    end
    for (int j = 0; j < k; j++) begin
      p = (longint'(a) * j + longint'(b) * j * j) % k;
      exp_q.push_back(tmp[p]);
      last_q.push_back(j == k - 1);
    end
  endtask

  task automatic start_blk(input int k, input int a, input int b,
                           input bit exp_err);
    CRC_start = 1'b1;
    blk_k = AW'(k);
    f1 = AW'(a);
    f2 = AW'(b);
    @(posedge clk); #1;
    CRC_start = 1'b0;
    @(negedge clk);
    chk("cfg_err", cfg_err, exp_err);
    @(posedge clk); #1;
  endtask

  task automatic write_beats(input int n);
    int got = 0;
    int guard = 0;
    bit acc;
    while (got < n && guard < 20000 && in_q.size() > 0) begin
      in_valid = 1'b1;
      in_data = in_q[0];
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        void'(in_q.pop_front());
        got++;
      end
      guard++;
    end
    in_valid = 1'b0;
    if (got < n) chk("write_timeout", got, n);
  endtask

  task automatic drain(input int n, input bit bp, input int hold,
                       input bit gapchk);
    int got = 0;
    int guard = 0;
    int first = -1;
    int lastc = 0;
    bit hv = 0;
    bit acc, lst;
    logic [DW-1:0] hd;
    while (got < n && guard < 30000) begin
      if (hold > 0) begin
        out_ready = 1'b0;
        hold--;
      end else begin
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      if (in_ready && out_valid) overlap = 1'b1;
      if (hv) chk("stall_hold", {out_valid, out_data}, {1'b1, hd});
      acc = out_valid && out_ready;
      hv = out_valid && !out_ready;
      hd = out_data;
      lst = 1'b0;
      if (acc) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          lst = last_q.pop_front();
          chk("out_data", out_data, exp_q.pop_front());
          chk("out_last", out_last, lst);
        end
        if (first < 0) first = cyc;
        lastc = cyc;
        got++;
      end
      chk("done", done, lst);
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b0;
    if (got < n) chk("drain_timeout", got, n);
    if (gapchk) chk("gap", lastc - first, n - 1);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk(tag, {in_ready, cfg_err, out_valid, out_last, done, out_data},
        '0);
  endtask

  initial begin
    reset = 1'b1;
    CRC_start = 1'b0;
    blk_k = '0;
    f1 = '0;
    f2 = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    overlap = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outs("reset_outs");
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic K=40 permutation: 0,13,6,19,...
    gen_block(40, 3, 10, 0);
    start_blk(40, 3, 10, 0);
    write_beats(40);
    drain(40, 0, 0, 0);

    // Largest block, full-rate drain
    gen_block(6144, 263, 480, 1);
    start_blk(6144, 263, 480, 0);
    write_beats(6144);
    drain(6144, 0, 0, 1);

    // Ping-pong: second block written while first drains, no gap
    gen_block(40, 3, 10, 1);
    gen_block(48, 7, 12, 1);
    start_blk(40, 3, 10, 0);
    write_beats(40);
    overlap = 1'b0;
    fork
      begin
        start_blk(48, 7, 12, 0);
        write_beats(48);
      end
      drain(88, 0, 20, 1);
    join
    chk("overlap", overlap, 1);

    // Both banks full then random backpressure
    gen_block(40, 3, 10, 1);
    start_blk(40, 3, 10, 0);
    write_beats(40);
    gen_block(48, 7, 12, 1);
    start_blk(48, 7, 12, 0);
    write_beats(48);
    start_blk(40, 3, 10, 1);
    chk("full_in_ready", in_ready, 0);
    drain(88, 1, 0, 0);

    // Config errors
    start_blk(44, 3, 10, 1);
    chk("k44_in_ready", in_ready, 0);
    start_blk(32, 3, 10, 1);
    chk("k32_in_ready", in_ready, 0);
    start_blk(40, 40, 10, 1);
    chk("f1_in_ready", in_ready, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("err_no_bank", out_valid, 0);
    gen_block(40, 3, 10, 1);
    start_blk(40, 3, 10, 0);
    start_blk(48, 7, 12, 1);
    chk("fill_in_ready", in_ready, 1);
    write_beats(40);
    drain(40, 0, 0, 0);

    // Reset during read
    gen_block(40, 3, 10, 1);
    start_blk(40, 3, 10, 0);
    write_beats(40);
    drain(20, 0, 0, 0);
    chk("pre_rst_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1 chk_idle_outs("rst_read_outs");
    @(posedge clk); #1;
    reset = 1'b0;
    in_q.delete();
    exp_q.delete();
    last_q.delete();

    // Reset during write
    gen_block(40, 3, 10, 1);
    start_blk(40, 3, 10, 0);
    write_beats(10);
    chk("pre_rst_ready", in_ready, 1);
    #2 reset = 1'b1;
    #1 chk_idle_outs("rst_write_outs");
    @(posedge clk); #1;
    reset = 1'b0;
    in_q.delete();
    exp_q.delete();
    last_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", out_valid, 0);

    gen_block(40, 3, 10, 0);
    start_blk(40, 3, 10, 0);
    write_beats(40);
    drain(40, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
